// File: rtl/dds_sine_gen.sv
// Direct-digital-synthesis sine generator: phase accumulator, quarter-wave LUT with
// quadrant folding and a two-stage registered output carrying valid and wrap strobes.
module dds_sine_gen #(
  parameter int ACC_W   = 24,
  parameter int PHASE_W = 8,
  parameter int OUT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               sync_clr,
  input  logic               fcw_load,
  input  logic [ACC_W-1:0]   fcw,
  input  logic [PHASE_W-1:0] phase_off,
  output logic [OUT_W-1:0]   sample_o,
  output logic               valid_o,
  output logic               wrap_o
);

  localparam int AW    = PHASE_W - 2;
  localparam int LUT_N = 2 ** AW;
  localparam logic [OUT_W-1:0] MID = {1'b1, {(OUT_W-1){1'b0}}};
  localparam real PI  = 3.14159265358979323846;
  localparam real AMP = real'(2 ** (OUT_W - 1) - 1);

  // Quarter-wave table sampled at half-step offsets so folding is exactly symmetric.
  logic [OUT_W-2:0] lut [LUT_N];
  for (genvar k = 0; k < LUT_N; k++) begin : g_lut
    localparam real ANG = 2.0 * PI * (real'(k) + 0.5) / real'(2 ** PHASE_W);
    localparam int  VAL = $rtoi(AMP * $sin(ANG) + 0.5);
    assign lut[k] = VAL[OUT_W-2:0];
  end

  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   fcw_r;
  logic               carry_r;
  logic               s1_neg;
  logic [AW-1:0]      s1_addr;
  logic               s1_valid;
  logic               s1_wrap;

  logic [PHASE_W-1:0] idx;
  logic [1:0]         quad;
  logic [AW-1:0]      addr;
  logic [OUT_W-1:0]   mag;

  always_comb begin
    idx  = acc[ACC_W-1 -: PHASE_W] + phase_off;
    quad = idx[PHASE_W-1 -: 2];
    addr = quad[0] ? ~idx[AW-1:0] : idx[AW-1:0];
  end

  assign mag = {1'b0, lut[s1_addr]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcw_r <= '0;
    end else if (fcw_load) begin
      fcw_r <= fcw;
    end
  end

  // Only the sign half of the quadrant survives S1; the mirror bit is already folded into addr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      carry_r  <= 1'b0;
      s1_neg   <= 1'b0;
      s1_addr  <= '0;
      s1_valid <= 1'b0;
      s1_wrap  <= 1'b0;
    end else if (sync_clr) begin
      acc      <= '0;
      carry_r  <= 1'b0;
      s1_valid <= 1'b0;
      s1_wrap  <= 1'b0;
    end else if (en) begin
      s1_neg            <= quad[1];
      s1_addr           <= addr;
      s1_valid          <= 1'b1;
      s1_wrap           <= carry_r;
      {carry_r, acc}    <= {1'b0, acc} + {1'b0, fcw_r};
    end else begin
      s1_valid <= 1'b0;
      s1_wrap  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_o <= MID;
      valid_o  <= 1'b0;
      wrap_o   <= 1'b0;
    end else begin
      valid_o <= s1_valid;
      wrap_o  <= s1_wrap;
      if (s1_valid) begin
        sample_o <= s1_neg ? (MID - mag) : (MID + mag);
      end
    end
  end

endmodule

// File: tb/tb_dds_sine_gen.sv
// Self-checking bench for dds_sine_gen: an 8-bit-accumulator instance and a default
// (24-bit) instance checked against a phase/sine reference model.
module tb_dds_sine_gen;

  localparam real PI = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        sync_clr = 1'b0;
  logic        fcw_load = 1'b0;
  logic [7:0]  fcw8 = '0;
  logic [23:0] fcw24 = '0;
  logic [7:0]  poff = '0;
  logic [7:0]  s8, s24;
  logic        v8, w8, v24, w24;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit              sel24 = 1'b0;
  int              m_accw = 8;
  longint unsigned m_mod = 256;
  longint unsigned m_phase, m_fcw;
  bit              m_wrap_pend;
  int              m_poff = 0;
  int              mq_s[$];
  bit              mq_w[$];
  bit              en_a, en_b;
  logic [7:0]      last_sample;
  logic            exp_valid, exp_wrap;
  logic [7:0]      exp_sample;
  logic [9:0]      o;

  dds_sine_gen #(.ACC_W(8), .PHASE_W(8), .OUT_W(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .sync_clr(sync_clr), .fcw_load(fcw_load),
    .fcw(fcw8), .phase_off(poff), .sample_o(s8), .valid_o(v8), .wrap_o(w8)
  );

  dds_sine_gen #(.ACC_W(24), .PHASE_W(8), .OUT_W(8)) dut24 (
    .clk(clk), .rst(rst), .en(en), .sync_clr(sync_clr), .fcw_load(fcw_load),
    .fcw(fcw24), .phase_off(poff), .sample_o(s24), .valid_o(v24), .wrap_o(w24)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  function automatic int sine_ref(int i);
    real s;
    int  r;
    s = $sin(2.0 * PI * (real'(i) + 0.5) / 256.0);
    r = $rtoi(127.0 * (s < 0.0 ? -s : s) + 0.5);
    return (s >= 0.0) ? 128 + r : 128 - r;
  endfunction

  function automatic logic [9:0] obs();
    return sel24 ? {v24, w24, s24} : {v8, w8, s8};
  endfunction

  function automatic logic [9:0] expv();
    return {exp_valid, exp_wrap, exp_sample};
  endfunction

  task automatic model_reset();
    mq_s.delete();
    mq_w.delete();
    en_a = 1'b0;
    en_b = 1'b0;
    m_phase = 0;
    m_fcw = 0;
    m_wrap_pend = 1'b0;
    last_sample = 8'h80;
  endtask

  // Drive one cycle from a negedge, predict the edge, return at the next negedge.
  task automatic tick(input bit e, input bit c, input bit l, input longint unsigned f);
    int              idx;
    longint unsigned nxt;
    en = e; sync_clr = c; fcw_load = l;
    fcw8 = f[7:0]; fcw24 = f[23:0]; poff = m_poff[7:0];
    en_b = en_a;
    en_a = e && !c;
    if (c) begin
      m_phase = 0;
      m_wrap_pend = 1'b0;
    end else if (e) begin
      idx = int'(((m_phase >> (m_accw - 8)) + longint'(m_poff)) % 256);
      mq_s.push_back(sine_ref(idx));
      mq_w.push_back(m_wrap_pend);
      nxt = m_phase + m_fcw;
      m_wrap_pend = (nxt >= m_mod);
      m_phase = nxt % m_mod;
    end
    if (l) m_fcw = f % m_mod;
    @(posedge clk);
    @(negedge clk);
    exp_valid = en_b;
    exp_wrap = 1'b0;
    if (en_b && mq_s.size() > 0) begin
      last_sample = 8'(mq_s.pop_front());
      exp_wrap = mq_w.pop_front();
    end
    exp_sample = last_sample;
    o = obs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({v8, w8, s8} !== 10'h080) begin
      errors++; $display("FAIL reset8 got v/w/s=%b/%b/%h exp 0/0/80", v8, w8, s8);
    end
    checks++;
    if ({v24, w24, s24} !== 10'h080) begin
      errors++; $display("FAIL reset24 got v/w/s=%b/%b/%h exp 0/0/80", v24, w24, s24);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_full_table();
    int cs[$]; bit cw[$];
    tick(0, 1, 1, 1);
    for (int i = 0; i < 262; i++) begin
      tick(1, 0, 0, 1);
      checks++;
      if (o !== expv()) begin
        errors++; $display("FAIL full_table i=%0d got %b/%b/%h exp %b/%b/%h",
                           i, o[9], o[8], o[7:0], exp_valid, exp_wrap, exp_sample);
      end
      if (o[9]) begin cs.push_back(int'(o[7:0])); cw.push_back(o[8]); end
    end
    checks++;
    if (cs.size() < 257 || cs[0] != 'h82 || cs[64] != 'hFF || cs[128] != 'h7E || cs[192] != 'h01) begin
      errors++; $display("FAIL full_table_points n=%0d got %h %h %h %h exp 82 ff 7e 01",
                         cs.size(), cs[0], cs[64], cs[128], cs[192]);
    end
    checks++;
    if (cw[0] !== 1'b0 || cw[255] !== 1'b0 || cw[256] !== 1'b1) begin
      errors++; $display("FAIL full_table_wrap got %b %b %b exp 0 0 1", cw[0], cw[255], cw[256]);
    end
  endtask

  task automatic run_pattern_test(input int off, input int pat[4], input bit chk_wrap);
    int n = 0;
    m_poff = off;
    tick(0, 0, 0, 64);
    tick(0, 0, 0, 64);
    tick(0, 1, 1, 64);
    for (int i = 0; i < 16; i++) begin
      tick(1, 0, 0, 64);
      checks++;
      if (o !== expv()) begin
        errors++; $display("FAIL pattern_model off=%0d i=%0d got %b/%b/%h exp %b/%b/%h",
                           off, i, o[9], o[8], o[7:0], exp_valid, exp_wrap, exp_sample);
      end
      if (o[9]) begin
        checks++;
        if (int'(o[7:0]) != pat[n % 4] || (chk_wrap && o[8] !== (n % 4 == 0 && n > 0))) begin
          errors++; $display("FAIL pattern off=%0d n=%0d got %h wrap %b exp %h",
                             off, n, o[7:0], o[8], pat[n % 4]);
        end
        n++;
      end
    end
  endtask

  task automatic test_quadrant();
    run_pattern_test(0, '{'h82, 'hFF, 'h7E, 'h01}, 1'b1);
  endtask

  task automatic test_phase_offset();
    run_pattern_test(64, '{'hFF, 'h7E, 'h01, 'h82}, 1'b0);
    m_poff = 0;
  endtask

  task automatic test_en_gaps();
    int n = 0;
    bit e, prev_e;
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    tick(0, 1, 1, 1);
    prev_e = 1'b0;
    for (int i = 0; i < 40; i++) begin
      e = (i % 5) < 3;
      tick(e, 0, 0, 1);
      checks++;
      if (o !== expv() || o[9] !== prev_e) begin
        errors++; $display("FAIL en_gaps i=%0d got %b/%b/%h exp %b/%b/%h",
                           i, o[9], o[8], o[7:0], prev_e, exp_wrap, exp_sample);
      end
      if (o[9]) begin
        checks++;
        if (int'(o[7:0]) != sine_ref(n)) begin
          errors++; $display("FAIL en_gaps_seq n=%0d got %h exp %h", n, o[7:0], sine_ref(n));
        end
        n++;
      end
      prev_e = e;
    end
    for (int i = 0; i < 60; i++) begin
      tick(bit'($urandom_range(0, 1)), 0, 0, 1);
      checks++;
      if (o !== expv()) begin
        errors++; $display("FAIL en_random i=%0d got %b/%b/%h exp %b/%b/%h",
                           i, o[9], o[8], o[7:0], exp_valid, exp_wrap, exp_sample);
      end
    end
  endtask

  task automatic test_sync_clr();
    for (int i = 0; i < 10; i++) tick(1, 0, 0, 1);
    tick(1, 1, 0, 1);
    checks++;
    if (o[9] !== 1'b1) begin
      errors++; $display("FAIL clr_inflight got valid=%b exp 1", o[9]);
    end
    tick(1, 0, 0, 1);
    checks++;
    if (o[9] !== 1'b0 || o[8] !== 1'b0) begin
      errors++; $display("FAIL clr_gap got v/w=%b/%b exp 0/0", o[9], o[8]);
    end
    tick(1, 0, 0, 1);
    checks++;
    if (o !== {2'b10, 8'h82}) begin
      errors++; $display("FAIL clr_restart got %b/%b/%h exp 1/0/82", o[9], o[8], o[7:0]);
    end
  endtask

  task automatic test_async_reset();
    bit found = 1'b0;
    for (int i = 0; i < 7; i++) tick(1, 0, 0, 1);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({v8, w8, s8} !== 10'h080) begin
      errors++; $display("FAIL async_reset got %b/%b/%h exp 0/0/80", v8, w8, s8);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    tick(0, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      tick(1, 0, 0, 1);
      if (o[9] && !found) begin
        found = 1'b1;
        checks++;
        if (o[8:0] !== {1'b0, 8'h82}) begin
          errors++; $display("FAIL async_restart got w/s=%b/%h exp 0/82", o[8], o[7:0]);
        end
      end
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL async_restart_valid got none exp a valid sample");
    end
  endtask

  task automatic test_random();
    bit c, l;
    longint unsigned f = 0;
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 7) == 0) m_poff = int'($urandom_range(0, 255));
      l = ($urandom_range(0, 7) == 0);
      if (l) f = longint'($urandom_range(0, 255));
      c = ($urandom_range(0, 15) == 0);
      tick(bit'($urandom_range(0, 3) != 0), c, l, f);
      checks++;
      if (o !== expv()) begin
        errors++; $display("FAIL random i=%0d got %b/%b/%h exp %b/%b/%h",
                           i, o[9], o[8], o[7:0], exp_valid, exp_wrap, exp_sample);
      end
    end
    m_poff = 0;
  endtask

  task automatic test_defaults();
    int n = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sel24 = 1'b1; m_accw = 24; m_mod = 64'd1 << 24; m_poff = 0;
    model_reset();
    tick(0, 0, 1, 65536);
    for (int i = 0; i < 70; i++) begin
      tick(1, 0, 0, 65536);
      checks++;
      if (o !== expv() || (o[9] && int'(o[7:0]) != sine_ref(n))) begin
        errors++; $display("FAIL fine_step i=%0d got %b/%b/%h exp %b/%b/%h",
                           i, o[9], o[8], o[7:0], exp_valid, exp_wrap, 8'(sine_ref(n)));
      end
      if (o[9]) n++;
    end
    tick(0, 0, 0, 32768);
    tick(0, 0, 0, 32768);
    tick(0, 1, 1, 32768);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1, 0, 0, 32768);
      checks++;
      if (o !== expv() || (o[9] && int'(o[7:0]) != sine_ref(n / 2))) begin
        errors++; $display("FAIL half_step i=%0d got %b/%b/%h exp %b/%b/%h",
                           i, o[9], o[8], o[7:0], exp_valid, exp_wrap, 8'(sine_ref(n / 2)));
      end
      if (o[9]) n++;
    end
  endtask

  initial begin
    test_reset();
    test_full_table();
    test_quadrant();
    test_phase_offset();
    test_en_gaps();
    test_sync_clr();
    test_async_reset();
    test_random();
    test_defaults();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
